// File: rtl/skeleton_cpu.sv
// -----------------------------------------------------------------------------
// skeleton_cpu
//   Single-issue 32-bit CPU skeleton. Instructions come from an internal ROM,
//   are decoded and executed on an integer ALU, and the result is written back
//   to a 32x32 register file. Each instruction takes one processor_clock period,
//   which is two master clocks.
//
// Ports
//   clock            in   master clock; all architectural state updates on posedge
//   reset            in   synchronous, active-high
//   imem_clock       out  ~clock; the ROM output register loads on its rising edge
//   dmem_clock       out  ~clock; provided for an external data memory
//   processor_clock  out  phase flop; one instruction per period
//   regfile_clock    out  same as processor_clock; writes land on its rising edge
//   q                out  current instruction (ROM output register)
//   ALU_reg_test     out  ALU operand A = RF[rs]
//   ALU_reg_imm      out  ALU operand B = sext(imm) for non-R-type, RF[rt] for R-type
// -----------------------------------------------------------------------------
module skeleton_cpu #(
  parameter int    IMEM_DEPTH = 4096,
  parameter string IMEM_INIT  = "imem.mem"
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_clock,
  output logic        dmem_clock,
  output logic        processor_clock,
  output logic        regfile_clock,
  output logic [31:0] q,
  output logic [31:0] ALU_reg_test,
  output logic [31:0] ALU_reg_imm
);

  localparam int PC_W = $clog2(IMEM_DEPTH);

  typedef enum logic [4:0] {
    OP_RTYPE = 5'b00000,
    OP_ADDI  = 5'b00101
  } opcode_e;

  typedef enum logic [4:0] {
    FN_ADD = 5'b00000,
    FN_SUB = 5'b00001,
    FN_AND = 5'b00010,
    FN_OR  = 5'b00011,
    FN_SLL = 5'b00100,
    FN_SRA = 5'b00101
  } aluop_e;

  typedef struct packed {
    logic [4:0] op;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] shamt;
    logic [4:0] aluop;
    logic [1:0] pad;
  } instr_t;

  // Overflow status codes deposited in $30 instead of writing rd.
  localparam logic [31:0] OVF_ADD  = 32'd1;
  localparam logic [31:0] OVF_ADDI = 32'd2;
  localparam logic [31:0] OVF_SUB  = 32'd3;
  localparam logic [4:0]  OVF_REG  = 5'd30;

  // ---------------------------------------------------------------------------
  // Instruction ROM
  // ---------------------------------------------------------------------------
  logic [31:0] rom [IMEM_DEPTH];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic            phase_q, phase_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [31:0]     rf_q [32];
  logic [31:0]     rf_d [32];

  // ---------------------------------------------------------------------------
  // Decode and operand fetch
  // ---------------------------------------------------------------------------
  instr_t      instr;
  logic [31:0] sext_imm;
  logic [31:0] opnd_a, opnd_b;
  logic [31:0] sum, diff;
  logic        add_ovf, sub_ovf;
  logic        unused_pad;

  assign instr      = instr_t'(instr_q);
  assign sext_imm   = {{15{instr_q[16]}}, instr_q[16:0]};
  assign opnd_a     = rf_q[instr.rs];
  assign opnd_b     = (instr.op == OP_RTYPE) ? rf_q[instr.rt] : sext_imm;
  assign unused_pad = ^instr.pad;

  assign sum  = opnd_a + opnd_b;
  assign diff = opnd_a - opnd_b;
  // Signed overflow: operands agree in sign (add) or differ (sub) and the
  // result sign disagrees with operand A.
  assign add_ovf = (opnd_a[31] == opnd_b[31]) && (sum[31]  != opnd_a[31]);
  assign sub_ovf = (opnd_a[31] != opnd_b[31]) && (diff[31] != opnd_a[31]);

  // ---------------------------------------------------------------------------
  // Execute
  // ---------------------------------------------------------------------------
  logic [31:0] alu_res;
  logic        wr_en;
  logic        ovf;
  logic [31:0] ovf_code;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statements can leave a value held (no latch).
    alu_res  = '0;
    wr_en    = 1'b0;
    ovf      = 1'b0;
    ovf_code = '0;
    case (instr.op)
      OP_RTYPE: begin
        case (instr.aluop)
          FN_ADD: begin alu_res = sum;  wr_en = 1'b1; ovf = add_ovf; ovf_code = OVF_ADD; end
          FN_SUB: begin alu_res = diff; wr_en = 1'b1; ovf = sub_ovf; ovf_code = OVF_SUB; end
          FN_AND: begin alu_res = opnd_a & opnd_b; wr_en = 1'b1; end
          FN_OR:  begin alu_res = opnd_a | opnd_b; wr_en = 1'b1; end
          FN_SLL: begin alu_res = opnd_a << instr.shamt; wr_en = 1'b1; end
          FN_SRA: begin alu_res = $signed(opnd_a) >>> instr.shamt; wr_en = 1'b1; end
          default: ;
        endcase
      end
      OP_ADDI: begin
        alu_res  = sum;
        wr_en    = 1'b1;
        ovf      = add_ovf;
        ovf_code = OVF_ADDI;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next state: commit happens on the posedge where phase is 0
  // ---------------------------------------------------------------------------
  always_comb begin
    phase_d = ~phase_q;
    pc_d    = pc_q;
    rf_d    = rf_q;
    instr_d = rom[pc_q];
    if (!phase_q) begin
      pc_d = pc_q + 1'b1;
      if (ovf) begin
        rf_d[OVF_REG] = ovf_code;
      end else if (wr_en && (instr.rd != 5'd0)) begin
        rf_d[instr.rd] = alu_res;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q <= 1'b1;
      pc_q    <= '0;
      // NOTE: the register file is architecturally cleared by reset, so it is
      // built from resettable flops; the ROM is read-only and never reset.
      rf_q    <= '{default: '0};
    end else begin
      phase_q <= phase_d;
      pc_q    <= pc_d;
      rf_q    <= rf_d;
    end
  end

  // ROM output register on the opposite edge, so the instruction is settled
  // well before the next commit edge.
  always_ff @(negedge clock) begin
    instr_q <= instr_d;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign imem_clock      = ~clock;
  assign dmem_clock      = ~clock;
  assign processor_clock = phase_q;
  assign regfile_clock   = phase_q;
  assign q               = instr_q;
  assign ALU_reg_test    = opnd_a;
  assign ALU_reg_imm     = opnd_b;

endmodule

// File: tb/tb_skeleton_cpu.sv
// -----------------------------------------------------------------------------
// tb_skeleton_cpu
//   Loads a directed program into the core's ROM, steps it one instruction per
//   processor_clock period and compares the fetched instruction and both ALU
//   operands against hand-computed values. Register results are observed
//   through the operand of a following instruction.
// -----------------------------------------------------------------------------
module tb_skeleton_cpu;

  logic        clock;
  logic        reset;
  logic        imem_clock;
  logic        dmem_clock;
  logic        processor_clock;
  logic        regfile_clock;
  logic [31:0] q;
  logic [31:0] ALU_reg_test;
  logic [31:0] ALU_reg_imm;

  skeleton_cpu #(
    .IMEM_DEPTH(4096),
    .IMEM_INIT ("")
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_clock     (imem_clock),
    .dmem_clock     (dmem_clock),
    .processor_clock(processor_clock),
    .regfile_clock  (regfile_clock),
    .q              (q),
    .ALU_reg_test   (ALU_reg_test),
    .ALU_reg_imm    (ALU_reg_imm)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] exp_test;
    logic [31:0] exp_imm;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  localparam int OP_R    = 0;
  localparam int OP_ADDI = 5;

  function automatic logic [31:0] enc_i(input int op, input int rd, input int rs, input int imm);
    logic [4:0]  op5, rd5, rs5;
    logic [16:0] imm17;
    op5 = op[4:0]; rd5 = rd[4:0]; rs5 = rs[4:0]; imm17 = imm[16:0];
    return {op5, rd5, rs5, imm17};
  endfunction

  function automatic logic [31:0] enc_r(input int rd, input int rs, input int rt,
                                        input int sh, input int fn);
    logic [4:0] rd5, rs5, rt5, sh5, fn5;
    rd5 = rd[4:0]; rs5 = rs[4:0]; rt5 = rt[4:0]; sh5 = sh[4:0]; fn5 = fn[4:0];
    return {5'b00000, rd5, rs5, rt5, sh5, fn5, 2'b00};
  endfunction

  task automatic add_vec(input logic [31:0] instr, input logic [31:0] t, input logic [31:0] m);
    vec_t v;
    v.instr = instr; v.exp_test = t; v.exp_imm = m;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Advance to just after the next posedge where processor_clock falls.
  task automatic wait_pfall(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clock);
      #1;
      if (!processor_clock) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_step(input int i);
    bit ok;
    wait_pfall(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL step%0d_pfall: no processor_clock fall within 4 clocks", i);
    end
    check($sformatf("step%0d_q", i),    q,            vecs[i].instr);
    check($sformatf("step%0d_test", i), ALU_reg_test, vecs[i].exp_test);
    check($sformatf("step%0d_imm", i),  ALU_reg_imm,  vecs[i].exp_imm);
  endtask

  initial begin
    // Program with operand values expected when each instruction is in q.
    add_vec(enc_i(OP_ADDI, 5, 5, 0),        32'h0,        32'h0);        // 0  shows RF[5] after reset
    add_vec(enc_i(OP_ADDI, 1, 0, 5),        32'h0,        32'h5);        // 1
    add_vec(enc_i(OP_ADDI, 2, 0, 3),        32'h0,        32'h3);        // 2
    add_vec(enc_r(3, 1, 2, 0, 0),           32'h5,        32'h3);        // 3  add
    add_vec(enc_i(OP_ADDI, 3, 3, 0),        32'h8,        32'h0);        // 4
    add_vec(enc_r(4, 1, 2, 0, 1),           32'h5,        32'h3);        // 5  sub
    add_vec(enc_i(OP_ADDI, 4, 4, 0),        32'h2,        32'h0);        // 6
    add_vec(enc_r(6, 1, 2, 0, 2),           32'h5,        32'h3);        // 7  and
    add_vec(enc_i(OP_ADDI, 6, 6, 0),        32'h1,        32'h0);        // 8
    add_vec(enc_r(7, 0, 2, 0, 3),           32'h0,        32'h3);        // 9  or
    add_vec(enc_i(OP_ADDI, 7, 7, 0),        32'h3,        32'h0);        // 10
    add_vec(enc_r(8, 1, 0, 2, 4),           32'h5,        32'h0);        // 11 sll 2
    add_vec(enc_i(OP_ADDI, 8, 8, 0),        32'd20,       32'h0);        // 12
    add_vec(enc_r(9, 3, 0, 1, 5),           32'h8,        32'h0);        // 13 sra 1
    add_vec(enc_i(OP_ADDI, 9, 9, 0),        32'h4,        32'h0);        // 14
    add_vec(enc_i(OP_ADDI, 24, 0, 'h10000), 32'h0,        32'hFFFF0000); // 15 sext
    add_vec(enc_i(OP_ADDI, 24, 24, 0),      32'hFFFF0000, 32'h0);        // 16
    add_vec(enc_r(13, 24, 0, 4, 5),         32'hFFFF0000, 32'h0);        // 17 sra negative
    add_vec(enc_i(OP_ADDI, 13, 13, 0),      32'hFFFFF000, 32'h0);        // 18
    add_vec(enc_i(OP_ADDI, 20, 0, 1),       32'h0,        32'h1);        // 19
    add_vec(enc_r(20, 20, 0, 30, 4),        32'h1,        32'h0);        // 20 sll 30
    add_vec(enc_r(21, 20, 20, 0, 0),        32'h40000000, 32'h40000000); // 21 add overflow
    add_vec(enc_i(OP_ADDI, 5, 30, 0),       32'h1,        32'h0);        // 22 $30
    add_vec(enc_i(OP_ADDI, 21, 21, 0),      32'h0,        32'h0);        // 23 $21 unwritten
    add_vec(enc_i(OP_ADDI, 22, 20, 'h1FFFF),32'h40000000, 32'hFFFFFFFF); // 24
    add_vec(enc_r(22, 22, 20, 0, 0),        32'h3FFFFFFF, 32'h40000000); // 25
    add_vec(enc_i(OP_ADDI, 23, 22, 1),      32'h7FFFFFFF, 32'h1);        // 26 addi overflow
    add_vec(enc_i(OP_ADDI, 5, 30, 0),       32'h2,        32'h0);        // 27
    add_vec(enc_i(OP_ADDI, 23, 23, 0),      32'h0,        32'h0);        // 28
    add_vec(enc_r(10, 1, 0, 31, 4),         32'h5,        32'h0);        // 29 sll 31
    add_vec(enc_i(OP_ADDI, 11, 0, 1),       32'h0,        32'h1);        // 30
    add_vec(enc_r(25, 10, 11, 0, 1),        32'h80000000, 32'h1);        // 31 sub overflow
    add_vec(enc_i(OP_ADDI, 5, 30, 0),       32'h3,        32'h0);        // 32
    add_vec(enc_i(OP_ADDI, 25, 25, 0),      32'h0,        32'h0);        // 33
    add_vec(enc_r(14, 10, 0, 1, 4),         32'h80000000, 32'h0);        // 34 sll, no ovf
    add_vec(enc_i(OP_ADDI, 5, 30, 0),       32'h3,        32'h0);        // 35 $30 kept
    add_vec(enc_i(OP_ADDI, 0, 0, 7),        32'h0,        32'h7);        // 36 write $0
    add_vec(enc_i(OP_ADDI, 1, 0, 0),        32'h0,        32'h0);        // 37 $0 still 0
    add_vec(enc_i(31, 2, 3, 5),             32'h8,        32'h5);        // 38 undefined op
    add_vec(enc_r(2, 3, 3, 0, 7),           32'h8,        32'h8);        // 39 undefined aluop
    add_vec(enc_i(OP_ADDI, 2, 2, 0),        32'h3,        32'h0);        // 40 $2 unchanged
    add_vec(enc_i(OP_ADDI, 3, 3, 0),        32'h8,        32'h0);        // 41

    for (int i = 0; i < 4096; i++) dut.rom[i] = '0;
    foreach (vecs[i]) dut.rom[i] = vecs[i].instr;

    // Reset state.
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_pclk",   {31'b0, processor_clock}, 32'h1);
    check("rst_rfclk",  {31'b0, regfile_clock},   32'h1);
    check("rst_imemclk",{31'b0, imem_clock},      32'h0);
    check("rst_q",      q,                        vecs[0].instr);
    check("rst_test",   ALU_reg_test,             32'h0);
    #5;
    check("rst_dmemclk",{31'b0, dmem_clock},      32'h1);
    @(posedge clock);
    #1;
    reset = 1'b0;

    foreach (vecs[i]) run_step(i);

    // Mid-program reset while instruction 41 is in flight.
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("mid_rst_pclk", {31'b0, processor_clock}, 32'h1);
    reset = 1'b0;

    // $5 held 3 before reset; instruction 0 must now read it as 0.
    for (int i = 0; i < 4; i++) run_step(i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
